// File: rtl/md_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// 32-step shift-add multiply or restoring divide, with pipeline stall and flush abort.
module md_seq #(
  parameter int XLEN  = 32,  // only 32 is supported
  parameter int STEPS = 32   // must equal XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            stall
);

  localparam int              CW      = $clog2(STEPS);
  localparam logic [CW-1:0]   LAST    = CW'(STEPS - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [2:0]      op;
  logic [XLEN-1:0] m;          // multiplicand (MUL*) or divisor magnitude (DIV*)
  logic [XLEN-1:0] hi, lo;     // product {hi,lo}, or remainder hi / quotient lo
  logic [XLEN-1:0] result_q;
  logic            neg_q, neg_r;
  logic [CW-1:0]   count;

  logic            sgn1, sgn2, neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;
  logic            accept, div_zero, div_ovf;

  // Which operands are treated as signed depends on the op.
  assign sgn1 = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign sgn2 = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign neg1 = sgn1 & rs1[XLEN-1];
  assign neg2 = sgn2 & rs2[XLEN-1];
  assign mag1 = neg1 ? -rs1 : rs1;
  assign mag2 = neg2 ? -rs2 : rs2;

  assign accept   = (state == IDLE) & start & ~flush;
  assign div_zero = funct3[2] & (rs2 == '0);
  assign div_ovf  = funct3[2] & ~funct3[0] & (rs1 == MIN_NEG) & (rs2 == '1);

  // One iteration of each algorithm.
  logic [XLEN:0] sum, rem_sh, diff;
  assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign rem_sh = {hi, lo[XLEN-1]};
  assign diff   = rem_sh - {1'b0, m};

  // Sign fix-up applied to the raw magnitudes once the iterations are done.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, final_val;
  assign prod = neg_q ? -{hi, lo} : {hi, lo};
  assign quot = neg_q ? -lo : lo;
  assign rem  = neg_r ? -hi : hi;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    final_val = prod[XLEN-1:0];
    unique case (op)
      3'b000:                 final_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quot;
      default:                final_val = rem;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = (div_zero | div_ovf) ? DONE : CALC;
      CALC: begin
        if (flush)              state_next = IDLE;
        else if (count == LAST) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state == CALC);
  assign done   = (state == DONE) & ~flush;
  assign result = done ? final_val : result_q;
  assign stall  = busy | accept | ((state == DONE) & ~done);

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, not just control, so nothing is X after reset.
      state    <= IDLE;
      op       <= '0;
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op    <= funct3;
        count <= '0;
        hi    <= '0;
        m     <= funct3[2] ? mag2 : mag1;
        lo    <= funct3[2] ? mag1 : mag2;
        neg_q <= neg1 ^ neg2;
        neg_r <= funct3[2] & neg1;
        // Fast paths preload the final quotient/remainder with no sign fix-up.
        if (div_zero) begin
          hi    <= rs1;
          lo    <= '1;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end else if (div_ovf) begin
          lo    <= MIN_NEG;
          neg_q <= 1'b0;
          neg_r <= 1'b0;
        end
      end else if (state == CALC) begin
        count <= count + 1'b1;
        if (op[2]) begin
          hi <= diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ~diff[XLEN]};
        end else begin
          hi <= sum[XLEN:1];
          lo <= {sum[0], lo[XLEN-1:1]};
        end
      end
      if (done) result_q <= final_val;
    end
  end

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: directed spec scenarios plus randomized ops
// checked against an arithmetic reference model.
module tb_md_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, stall;
  logic [31:0] result;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_result;

  md_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result),
    .stall  (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge. Sample point: falling edge.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  // Reference model: full-width arithmetic straight from the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] x, y, p;
    int sa, sb, sr;
    sa = a;
    sb = b;
    x  = (f == 3'b001 || f == 3'b010) ? {{34{a[31]}}, a} : {34'd0, a};
    y  = (f == 3'b001)                 ? {{34{b[31]}}, b} : {34'd0, b};
    p  = x * y;
    case (f)
      3'b000: return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sr = sa / sb;
        return sr;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sr = sa % sb;
        return sr;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if (f[2] && !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op from IDLE (caller sits at a drive point) and check latency/result.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    int waited;
    bit seen;
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    to_sample();
    check1({tag, "_stall_at_start"}, stall, 1'b1);
    check1({tag, "_busy_at_start"}, busy, 1'b0);
    check({tag, "_result_held"}, result, last_result);
    to_drive();
    start  = 1'b0;
    funct3 = 3'($urandom);
    rs1    = $urandom;
    rs2    = $urandom;
    waited = 1;
    seen   = 1'b0;
    while (!seen && waited <= 40) begin
      to_sample();
      if (done) seen = 1'b1;
      else begin
        waited++;
        to_drive();
      end
    end
    check1({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_latency"}, 32'(waited), 32'(lat));
    check({tag, "_result"}, result, exp);
    last_result = exp;
    to_drive();
  endtask

  initial begin
    int ndone, dcyc;
    logic [2:0]  f;
    logic [31:0] a, b;

    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
    last_result = 32'd0;
    to_drive();
    to_drive();
    to_sample();
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check("rst_result", result, 32'd0);
    check1("rst_stall", stall, 1'b0);
    to_drive();
    rst = 1'b0;
    to_sample();
    check1("idle_stall", stall, 1'b0);
    to_drive();

    // MUL 7 * -3 with cycle-exact busy/done/stall timing.
    funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    for (int c = 0; c <= 33; c++) begin
      to_sample();
      check1($sformatf("mul_busy_c%0d", c), busy, (c >= 1 && c <= 32));
      check1($sformatf("mul_done_c%0d", c), done, (c == 33));
      check1($sformatf("mul_stall_c%0d", c), stall, (c <= 32));
      if (c == 33) check("mul_result", result, 32'hFFFF_FFEB);
      to_drive();
      if (c == 0) begin
        start = 1'b0; funct3 = 3'b101; rs1 = $urandom; rs2 = $urandom;
      end
    end
    last_result = 32'hFFFF_FFEB;

    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    do_op(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulhu");
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, "mulhsu");
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
    do_op(3'b101, 32'd100,       32'd7,         32'd14,        33, "divu");
    do_op(3'b111, 32'd100,       32'd7,         32'd2,         33, "remu");
    do_op(3'b101, 32'h1234,      32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
    do_op(3'b110, 32'h1234,      32'd0,         32'h1234,      1,  "rem_by0");
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");

    // Flush in CALC at cycle 10, restart at cycle 11.
    funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd6; start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) flush = 1'b1;
      to_sample();
      check1($sformatf("abort_done_c%0d", c), done, 1'b0);
      to_drive();
      if (c == 0) start = 1'b0;
    end
    flush = 1'b0;
    do_op(3'b101, 32'd9, 32'd3, 32'd3, 33, "after_abort");

    // Flush landing exactly on the DONE cycle.
    funct3 = 3'b011; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    for (int c = 0; c <= 32; c++) begin
      to_sample();
      check1($sformatf("fdone_done_c%0d", c), done, 1'b0);
      to_drive();
      if (c == 0) start = 1'b0;
    end
    flush = 1'b1;
    to_sample();
    check1("fdone_done", done, 1'b0);
    check1("fdone_busy", busy, 1'b0);
    check1("fdone_stall", stall, 1'b1);
    check("fdone_result", result, last_result);
    to_drive();
    flush = 1'b0;
    to_sample();
    check1("fdone_after_done", done, 1'b0);
    check("fdone_after_result", result, last_result);
    to_drive();

    // Second start during a running op is ignored.
    funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd10; start = 1'b1;
    ndone = 0; dcyc = -1;
    for (int c = 0; c <= 45; c++) begin
      if (c == 5) begin
        start = 1'b1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd3;
      end
      if (c == 6) start = 1'b0;
      to_sample();
      if (done) begin
        ndone++;
        dcyc = c;
        check("ignore_result", result, 32'd100);
      end
      to_drive();
      if (c == 0) start = 1'b0;
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_done_cycle", 32'(dcyc), 32'd33);
    last_result = 32'd100;

    // Reset in the middle of an operation at cycle 20.
    funct3 = 3'b100; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7; start = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c == 20) rst = 1'b1;
      to_sample();
      to_drive();
      if (c == 0) start = 1'b0;
    end
    rst = 1'b0;
    to_sample();
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_done", done, 1'b0);
    check("midrst_result", result, 32'd0);
    check1("midrst_stall", stall, 1'b0);
    last_result = 32'd0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      to_drive();
      to_sample();
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    to_drive();

    // start and flush together in IDLE: nothing starts (a fast-path op would finish next cycle).
    funct3 = 3'b101; rs1 = 32'd8; rs2 = 32'd0; start = 1'b1; flush = 1'b1;
    to_sample();
    check1("sf_stall", stall, 1'b0);
    to_drive();
    start = 1'b0; flush = 1'b0;
    to_sample();
    check1("sf_busy", busy, 1'b0);
    check1("sf_done", done, 1'b0);
    check("sf_result", result, last_result);
    to_drive();

    // Randomized ops with corner-case bias.
    for (int i = 0; i < 60; i++) begin
      int r;
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (r == 2) b = $urandom_range(1, 15);
      if (r == 3) a = $urandom_range(0, 300);
      do_op(f, a, b, model(f, a, b), model_lat(f, a, b), $sformatf("rnd%0d_f%0d", i, f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_seq.md
Name: md_seq

Overview:
- Iterative RV32M multiply/divide sequencer beside the main ALU in the EX stage.
- Accepts one operation per start pulse and runs a 32-step shift-add multiply or restoring divide. Returns a 32-bit result with a one-cycle done pulse.
- Drives stall so the pipeline holds the issuing instruction in EX until the result is ready.
- Honours pipeline flush (branch/jump redirect) by aborting the operation silently.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- STEPS, 32, iteration count; must equal XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request from EX; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  32  operand A (multiplicand/dividend).
- rs2  input  32  operand B (multiplier/divisor).
- flush  input  1  pipeline redirect; aborts any operation in flight.
- busy  output  1  high in CALC.
- done  output  1  one-cycle pulse; result valid in the same cycle.
- result  output  32  last completed result; held until the next done.
- stall  output  1  combinational: busy | (start & state==IDLE & ~flush) | (state==DONE & ~done); holds the pipeline.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, count=0, all internal registers 0. Reset mid-operation abandons it with no done.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0: latch funct3, capture operand magnitudes and sign flags, count=0.
  - Go to CALC, except on the divide fast paths below, which go to DONE.
- Multiply signedness:
  - MULH: rs1 and rs2 signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU and MUL: both operands unsigned magnitudes. MUL low word is sign-agnostic.
  - Product sign = XOR of the signed-operand signs. Result is the negated 64-bit product when the sign is negative.
  - MUL returns bits[31:0]; MULH/MULHSU/MULHU return bits[63:32].
- Divide: DIV/REM signed, DIVU/REMU unsigned.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder takes the sign of rs1.
- CALC: one iteration per cycle; count increments.
  - After the iteration with count==31, go to DONE. CALC therefore lasts exactly 32 cycles.
- DONE: done=1, result register updated in that cycle, busy=0, stall=0. Always returns to IDLE next cycle.
- Latency: start high in cycle N gives done in cycle N+33.
- Fast paths (no CALC; done in cycle N+1):
  - Divide by zero: DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- start while not IDLE: ignored; no queueing.
- Operands: used only as latched at start. rs1/rs2/funct3 changes after the start cycle have no effect.
- flush in CALC or DONE: next state IDLE; done forced 0 in that cycle; result unchanged.
- flush with start in IDLE: flush wins; start ignored; stall=0.
- New start accepted in the cycle immediately after DONE or after a flush.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start in cycle 0 -> busy cycles 1-32, done cycle 33, result=0xFFFFFFEB; stall high cycles 0-32.
- MULH rs1=rs2=0x80000000 -> result=0x40000000. MULHU same operands -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU rs1=0x1234, rs2=0 -> done cycle 1, result 0xFFFFFFFF. REM rs2=0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> done cycle 1, result 0x80000000.
- Abort: start MUL cycle 0, flush cycle 10 -> busy=0 cycle 11, no done ever, result keeps its prior value. start cycle 11 (DIVU 9/3) -> done cycle 44, result 3.
- Corner cases:
  - start pulsed in cycle 5 of a running op -> ignored; exactly one done.
  - rst asserted cycle 20 -> all outputs 0 cycle 21.
  - start+flush together in IDLE -> no operation, stall=0.
